inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 12: instruction memory byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in WAIT before a fault.
REQ-004 SHALL have port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port I_MEM_CSN, output, 1: instruction memory chip select, active-low.
REQ-007 SHALL have port I_MEM_ADDR, output, IMEM_AW: byte address, equal to PC[IMEM_AW-1:0].
REQ-008 SHALL have port I_MEM_DI, input, 32: instruction word returned by memory.
REQ-009 SHALL have port I_MEM_VALID, input, 1: I_MEM_DI is valid this cycle.
REQ-010 SHALL have port INST, output, 32: latched instruction presented to decode.
REQ-011 SHALL have port INST_VALID, output, 1: INST is valid; drives the decode activate input.
REQ-012 SHALL have port PC, output, 32: address of INST.
REQ-013 SHALL have port PC_PLUS4, output, 32: PC+4, modulo 2^32.
REQ-014 SHALL have port NEXT_REQ, input, 1: downstream has consumed INST; advance sequentially.
REQ-015 SHALL have port REDIRECT_EN, input, 1: taken branch, JAL or JALR; load REDIRECT_TARGET.
REQ-016 SHALL have port REDIRECT_TARGET, input, 32: redirect byte address.
REQ-017 SHALL have port HALT, input, 1: stop fetching.
REQ-018 SHALL have port FETCH_CNT, output, 32: count of completed fetches.
REQ-019 SHALL have port FAULT, output, 2: fault code; 0 = none, 1 = misaligned target, 2 = memory timeout.

Function
REQ-020 SHALL implement the states IDLE, REQ, WAIT, HOLD and HALTED.
REQ-021 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-022 REQ SHALL drive I_MEM_CSN=0 and I_MEM_ADDR from PC, then go to WAIT.
REQ-023 WAIT SHALL hold I_MEM_CSN=0 and increment a wait counter each cycle.
REQ-024 In WAIT with I_MEM_VALID=1: INST<=I_MEM_DI, FETCH_CNT+=1, go to HOLD; I_MEM_DI SHALL be ignored in every other state.
REQ-025 In WAIT, if the wait counter reaches TIMEOUT without I_MEM_VALID: FAULT<=2, go to HALTED.
REQ-026 I_MEM_CSN SHALL be 1 in IDLE, HOLD and HALTED.
REQ-027 INST_VALID SHALL be 1 exactly while in HOLD, registered, with no combinational path from inputs.
REQ-028 In HOLD, if REDIRECT_EN=1 and REDIRECT_TARGET[1:0]==0: PC<=REDIRECT_TARGET, go to REQ.
REQ-029 In HOLD, if REDIRECT_EN=1 and REDIRECT_TARGET[1:0]!=0: FAULT<=1, PC unchanged, go to HALTED.
REQ-030 In HOLD, if REDIRECT_EN=0 and NEXT_REQ=1: PC<=PC+4 with wrap (32'hFFFF_FFFC -> 0), go to REQ.
REQ-031 In HOLD, if REDIRECT_EN and NEXT_REQ are both 1, REDIRECT_EN SHALL take priority.
REQ-032 In HOLD with neither REDIRECT_EN nor NEXT_REQ: INST, PC and INST_VALID SHALL hold indefinitely.
REQ-033 REDIRECT_EN and NEXT_REQ SHALL be ignored outside HOLD.
REQ-034 HALT=1 in any state SHALL force HALTED next cycle, overriding every other transition in the same cycle; INST_VALID=0, I_MEM_CSN=1.
REQ-035 HALTED SHALL be exited only by RST; PC, INST and FETCH_CNT SHALL freeze there.
REQ-036 Latency SHALL be: a fetch with memory returning on the first WAIT cycle gives INST_VALID two cycles after leaving HOLD.
REQ-037 FETCH_CNT SHALL wrap modulo 2^32.

Reset
REQ-038 On RST=1 at a clock edge: state=IDLE, PC=RESET_PC, INST=0, INST_VALID=0, I_MEM_CSN=1, FETCH_CNT=0, FAULT=0, wait counter=0.
REQ-039 RST SHALL override every input, including HALT, and SHALL abort any fetch in flight; a late I_MEM_VALID is then ignored.
REQ-040 The first I_MEM_CSN=0 cycle SHALL be the second cycle after RST deasserts.

Verification
REQ-041 Reset release, memory VALID on the first WAIT cycle with DI=32'h0000_0013 -> INST=0x13, PC=0, INST_VALID=1 on the 4th cycle, FETCH_CNT=1.
REQ-042 HOLD at PC=0x8, NEXT_REQ=1 and REDIRECT_EN=1 with TARGET=0x40 in the same cycle -> next I_MEM_ADDR=0x040, PC=0x40.
REQ-043 Redirect with TARGET=0x42 -> FAULT=1, HALTED, I_MEM_CSN stays 1, PC unchanged.
REQ-044 Memory never asserts VALID -> FAULT=2 after 16 WAIT cycles, INST_VALID=0.
REQ-045 HALT pulse during WAIT, then VALID=1 -> INST unchanged, FETCH_CNT unchanged, HALTED until RST.
REQ-046 RESET_PC=32'hFFFF_FFFC, fetch then NEXT_REQ -> next PC=0, I_MEM_ADDR=0.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch FSM with redirect, halt, timeout and misalignment faults.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12,
    parameter int          TIMEOUT  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               I_MEM_CSN,
    output logic [IMEM_AW-1:0] I_MEM_ADDR,
    input  logic [31:0]        I_MEM_DI,
    input  logic               I_MEM_VALID,
    output logic [31:0]        INST,
    output logic               INST_VALID,
    output logic [31:0]        PC,
    output logic [31:0]        PC_PLUS4,
    input  logic               NEXT_REQ,
    input  logic               REDIRECT_EN,
    input  logic [31:0]        REDIRECT_TARGET,
    input  logic               HALT,
    output logic [31:0]        FETCH_CNT,
    output logic [1:0]         FAULT
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} state_t;
    state_t          state;
    logic [WW-1:0]   wait_cnt;
    assign I_MEM_ADDR = PC[IMEM_AW-1:0];
    assign PC_PLUS4   = PC + 32'd4;
    // I_MEM_CSN and INST_VALID are set on the edge entering each state, so both are pure flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            PC         <= RESET_PC;
            INST       <= '0;
            INST_VALID <= 1'b0;
            I_MEM_CSN  <= 1'b1;
            FETCH_CNT  <= '0;
            FAULT      <= '0;
            wait_cnt   <= '0;
        end else if (HALT) begin
            state      <= HALTED;
            INST_VALID <= 1'b0;
            I_MEM_CSN  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    I_MEM_CSN <= 1'b0;
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (I_MEM_VALID) begin
                        INST       <= I_MEM_DI;
                        FETCH_CNT  <= FETCH_CNT + 32'd1;
                        INST_VALID <= 1'b1;
                        I_MEM_CSN  <= 1'b1;
                        state      <= HOLD;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        FAULT     <= 2'd2;
                        I_MEM_CSN <= 1'b1;
                        state     <= HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (REDIRECT_EN && REDIRECT_TARGET[1:0] == 2'b00) begin
                        PC         <= REDIRECT_TARGET;
                        INST_VALID <= 1'b0;
                        I_MEM_CSN  <= 1'b0;
                        state      <= REQ;
                    end else if (REDIRECT_EN) begin
                        FAULT      <= 2'd1;
                        INST_VALID <= 1'b0;
                        state      <= HALTED;
                    end else if (NEXT_REQ) begin
                        PC         <= PC_PLUS4;
                        INST_VALID <= 1'b0;
                        I_MEM_CSN  <= 1'b0;
                        state      <= REQ;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a queue-based scoreboard checking each fetched instruction.
module tb_inst_fetch;
    logic        CLK = 1'b0;
    logic        RST, I_MEM_VALID, NEXT_REQ, REDIRECT_EN, HALT;
    logic [31:0] I_MEM_DI, REDIRECT_TARGET;
    logic        I_MEM_CSN, INST_VALID, d2_csn, d2_valid;
    logic [11:0] I_MEM_ADDR, d2_addr;
    logic [31:0] INST, PC, PC_PLUS4, FETCH_CNT, d2_inst, d2_pc, d2_plus4, d2_cnt;
    logic [1:0]  FAULT, d2_fault;
    int checks = 0;
    int errors = 0;
    typedef struct {logic [31:0] inst; logic [31:0] pc; logic [31:0] cnt;} exp_t;
    exp_t q[$];
    logic prev_valid = 1'b0;

    always #5 CLK = ~CLK;

    inst_fetch dut (
        .CLK(CLK), .RST(RST), .I_MEM_CSN(I_MEM_CSN), .I_MEM_ADDR(I_MEM_ADDR),
        .I_MEM_DI(I_MEM_DI), .I_MEM_VALID(I_MEM_VALID), .INST(INST), .INST_VALID(INST_VALID),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .NEXT_REQ(NEXT_REQ), .REDIRECT_EN(REDIRECT_EN),
        .REDIRECT_TARGET(REDIRECT_TARGET), .HALT(HALT), .FETCH_CNT(FETCH_CNT), .FAULT(FAULT)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST), .I_MEM_CSN(d2_csn), .I_MEM_ADDR(d2_addr),
        .I_MEM_DI(I_MEM_DI), .I_MEM_VALID(I_MEM_VALID), .INST(d2_inst), .INST_VALID(d2_valid),
        .PC(d2_pc), .PC_PLUS4(d2_plus4), .NEXT_REQ(NEXT_REQ), .REDIRECT_EN(REDIRECT_EN),
        .REDIRECT_TARGET(REDIRECT_TARGET), .HALT(HALT), .FETCH_CNT(d2_cnt), .FAULT(d2_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Called in the first WAIT cycle; memory answers after `waits` idle WAIT cycles.
    task automatic fetch(input logic [31:0] data, input int waits, input logic [31:0] pc, input logic [31:0] cnt);
        exp_t e;
        repeat (waits) tick;
        I_MEM_VALID = 1'b1;
        I_MEM_DI    = data;
        e.inst = data;
        e.pc   = pc;
        e.cnt  = cnt;
        q.push_back(e);
        tick;
        I_MEM_VALID = 1'b0;
        I_MEM_DI    = 32'hBAD0_BAD0;
    endtask

    always @(negedge CLK) begin
        if (INST_VALID && !prev_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got inst %h with empty queue", INST);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_inst", INST, e.inst);
                chk("sb_pc", PC, e.pc);
                chk("sb_cnt", FETCH_CNT, e.cnt);
            end
        end
        prev_valid <= INST_VALID;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1; I_MEM_VALID = 0; NEXT_REQ = 0; REDIRECT_EN = 0; HALT = 0;
        I_MEM_DI = 32'hBAD0_BAD0; REDIRECT_TARGET = 0;
        repeat (2) tick;
        chk("rst_valid", {31'd0, INST_VALID}, 0);
        chk("rst_csn", {31'd0, I_MEM_CSN}, 1);
        chk("rst_pc", PC, 0);
        chk("rst_inst", INST, 0);
        chk("rst_cnt", FETCH_CNT, 0);
        chk("rst_fault", {30'd0, FAULT}, 0);
        chk("rst_pc_wrap", d2_pc, 32'hFFFF_FFFC);
        RST = 0;
        chk("idle_csn", {31'd0, I_MEM_CSN}, 1);
        tick;
        chk("req_csn", {31'd0, I_MEM_CSN}, 0);
        chk("req_addr", {20'd0, I_MEM_ADDR}, 0);
        tick;
        fetch(32'h0000_0013, 0, 0, 1);
        chk("valid_4th", {31'd0, INST_VALID}, 1);
        repeat (3) tick;
        chk("hold_valid", {31'd0, INST_VALID}, 1);
        chk("hold_inst", INST, 32'h13);
        chk("hold_csn", {31'd0, I_MEM_CSN}, 1);
        chk("wrap_pc", d2_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", d2_plus4, 0);
        NEXT_REQ = 1;
        tick;
        NEXT_REQ = 0;
        chk("seq_pc", PC, 4);
        chk("seq_addr", {20'd0, I_MEM_ADDR}, 4);
        chk("seq_csn", {31'd0, I_MEM_CSN}, 0);
        chk("wrap_next_pc", d2_pc, 0);
        chk("wrap_next_addr", {20'd0, d2_addr}, 0);
        tick;
        fetch(32'h0040_0093, 2, 4, 2);
        NEXT_REQ = 1;
        tick;
        NEXT_REQ = 0;
        tick;
        fetch(32'h0080_0113, 0, 8, 3);
        chk("plus4", PC_PLUS4, 32'hC);
        NEXT_REQ = 1; REDIRECT_EN = 1; REDIRECT_TARGET = 32'h40;
        tick;
        NEXT_REQ = 0; REDIRECT_EN = 0;
        chk("redir_pc", PC, 32'h40);
        chk("redir_addr", {20'd0, I_MEM_ADDR}, 32'h40);
        chk("redir_csn", {31'd0, I_MEM_CSN}, 0);
        chk("redir_valid", {31'd0, INST_VALID}, 0);
        REDIRECT_EN = 1; REDIRECT_TARGET = 32'h80;
        tick;
        REDIRECT_EN = 0;
        chk("redir_ignored", PC, 32'h40);
        fetch(32'h0000_0463, 0, 32'h40, 4);
        REDIRECT_EN = 1; REDIRECT_TARGET = 32'h42;
        tick;
        REDIRECT_EN = 0;
        chk("mis_fault", {30'd0, FAULT}, 1);
        chk("mis_csn", {31'd0, I_MEM_CSN}, 1);
        chk("mis_valid", {31'd0, INST_VALID}, 0);
        chk("mis_pc", PC, 32'h40);
        NEXT_REQ = 1; I_MEM_VALID = 1; I_MEM_DI = 32'hDEAD_BEEF;
        repeat (3) tick;
        NEXT_REQ = 0; I_MEM_VALID = 0;
        chk("halted_pc", PC, 32'h40);
        chk("halted_csn", {31'd0, I_MEM_CSN}, 1);
        chk("halted_cnt", FETCH_CNT, 4);
        chk("halted_inst", INST, 32'h463);
        RST = 1;
        tick;
        RST = 0;
        chk("rst2_fault", {30'd0, FAULT}, 0);
        chk("rst2_pc", PC, 0);
        chk("rst2_cnt", FETCH_CNT, 0);
        tick;
        tick;
        fetch(32'h1234_5678, 15, 0, 1);
        NEXT_REQ = 1;
        tick;
        NEXT_REQ = 0;
        tick;
        repeat (15) tick;
        chk("to_csn_last", {31'd0, I_MEM_CSN}, 0);
        chk("to_fault_last", {30'd0, FAULT}, 0);
        tick;
        chk("to_fault", {30'd0, FAULT}, 2);
        chk("to_csn", {31'd0, I_MEM_CSN}, 1);
        chk("to_valid", {31'd0, INST_VALID}, 0);
        I_MEM_VALID = 1;
        tick;
        I_MEM_VALID = 0;
        chk("to_cnt", FETCH_CNT, 1);
        RST = 1; HALT = 1;
        tick;
        RST = 0; HALT = 0;
        chk("rst_over_halt_csn", {31'd0, I_MEM_CSN}, 1);
        chk("rst_over_halt_fault", {30'd0, FAULT}, 0);
        tick;
        chk("rst_over_halt_req", {31'd0, I_MEM_CSN}, 0);
        tick;
        HALT = 1; I_MEM_VALID = 1; I_MEM_DI = 32'hCAFE_F00D;
        tick;
        HALT = 0;
        chk("halt_valid", {31'd0, INST_VALID}, 0);
        chk("halt_csn", {31'd0, I_MEM_CSN}, 1);
        chk("halt_cnt", FETCH_CNT, 0);
        chk("halt_inst", INST, 0);
        repeat (2) tick;
        I_MEM_VALID = 0;
        chk("halt_stay_csn", {31'd0, I_MEM_CSN}, 1);
        chk("halt_stay_cnt", FETCH_CNT, 0);
        RST = 1;
        tick;
        RST = 0;
        tick;
        tick;
        RST = 1;
        tick;
        RST = 0; I_MEM_VALID = 1; I_MEM_DI = 32'hFFFF_0000;
        tick;
        I_MEM_VALID = 0;
        chk("abort_cnt", FETCH_CNT, 0);
        chk("abort_valid", {31'd0, INST_VALID}, 0);
        tick;
        fetch(32'h0000_00AB, 0, 0, 1);
        repeat (2) tick;
        chk("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
